// File: rtl/width_converter_cache_if.sv
// Memory request/response interface shared by the narrow and wide sides of width_converter_cache.
interface mem_intf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic                    wen;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   data;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;

    modport master (
        output req, wen, addr, be, data, r_ready,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, wen, addr, be, data, r_ready,
        output gnt, r_valid, r_data
    );
endinterface

// File: rtl/width_converter_cache.sv
// Narrow-to-wide memory width converter with a small fully associative read line buffer.
// Optional macro WCC_WRITE_UPDATE_EN: write hits merge into the buffered line instead of invalidating it.
module width_converter_cache #(
    parameter int unsigned MAS_DATA_WIDTH = 32,
    parameter int unsigned SLV_DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NB_LINES       = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        flush_i,
    mem_intf.slave      master_port,
    mem_intf.master     slave_port,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);
    localparam int unsigned RATIO     = SLV_DATA_WIDTH / MAS_DATA_WIDTH;
    localparam int unsigned MAS_BYTES = MAS_DATA_WIDTH / 8;
    localparam int unsigned SLV_BYTES = SLV_DATA_WIDTH / 8;
    localparam int unsigned OFF_LSB   = $clog2(MAS_BYTES);
    localparam int unsigned LINE_LSB  = $clog2(SLV_BYTES);
    localparam int unsigned OFF_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned TAG_W     = ADDR_WIDTH - LINE_LSB;
    localparam int unsigned IDX_W     = (NB_LINES > 1) ? $clog2(NB_LINES) : 1;

    generate
        if (NB_LINES < 1 || NB_LINES > 16) begin : g_bad_lines
            $error("width_converter_cache: NB_LINES must be in 1..16");
        end

        if ((SLV_DATA_WIDTH % MAS_DATA_WIDTH) != 0 || RATIO == 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
            $error("width_converter_cache: SLV_DATA_WIDTH must be a power-of-two multiple of MAS_DATA_WIDTH");
        end else if (RATIO == 1) begin : g_passthrough
            // Equal widths: straight wires, handshakes held low in reset.
            assign slave_port.req     = resetn_i & master_port.req;
            assign slave_port.wen     = master_port.wen;
            assign slave_port.addr    = master_port.addr;
            assign slave_port.be      = master_port.be;
            assign slave_port.data    = master_port.data;
            assign slave_port.r_ready = resetn_i & master_port.r_ready;
            assign master_port.gnt     = resetn_i & slave_port.gnt;
            assign master_port.r_valid = resetn_i & slave_port.r_valid;
            assign master_port.r_data  = slave_port.r_data;
            assign hit_cnt_o  = '0;
            assign miss_cnt_o = '0;
        end else begin : g_cache
            typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

            state_t                    r_state;
            logic [NB_LINES-1:0]       r_vld;
            logic [TAG_W-1:0]          r_tag  [NB_LINES];
            logic [SLV_DATA_WIDTH-1:0] r_line [NB_LINES];
            logic [IDX_W-1:0]          r_rr;
            logic [OFF_W-1:0]          r_off;
            logic [TAG_W-1:0]          r_pend_tag;
            logic                      r_flushed;
            logic [MAS_DATA_WIDTH-1:0] r_rdata;
            logic [31:0]               r_hit_cnt;
            logic [31:0]               r_miss_cnt;

            logic [TAG_W-1:0]          w_tag;
            logic [OFF_W-1:0]          w_off;
            logic [SLV_DATA_WIDTH-1:0] w_wdata;
            logic [SLV_BYTES-1:0]      w_be;
            logic                      w_hit;
            logic [IDX_W-1:0]          w_hit_idx;
            logic                      w_free;
            logic [IDX_W-1:0]          w_vict;
            logic [MAS_DATA_WIDTH-1:0] w_hit_word;
            logic [MAS_DATA_WIDTH-1:0] w_fill_word;
            logic                      w_idle_req;
            logic                      w_rd_hit;
            logic                      w_rd_miss_hs;
            logic                      w_wr_hs;
            logic                      w_wr_upd;
            logic                      w_store;
            logic                      w_s_req;
            logic                      w_s_rready;
            logic                      w_m_gnt;
            logic                      w_m_rvalid;
            logic [MAS_DATA_WIDTH-1:0] w_m_rdata;

            if (OFF_LSB > 0) begin : g_unused_addr
                logic w_unused_addr;
                assign w_unused_addr = ^master_port.addr[OFF_LSB-1:0];
            end

            assign w_tag       = master_port.addr[ADDR_WIDTH-1:LINE_LSB];
            assign w_off       = master_port.addr[LINE_LSB-1:OFF_LSB];
            assign w_wdata     = {RATIO{master_port.data}};
            assign w_be        = SLV_BYTES'(master_port.be) << (w_off * MAS_BYTES);
            assign w_hit_word  = r_line[w_hit_idx][w_off*MAS_DATA_WIDTH +: MAS_DATA_WIDTH];
            assign w_fill_word = slave_port.r_data[r_off*MAS_DATA_WIDTH +: MAS_DATA_WIDTH];

            assign w_idle_req   = resetn_i && (r_state == IDLE) && master_port.req;
            assign w_rd_hit     = w_idle_req && !master_port.wen && w_hit;
            assign w_rd_miss_hs = w_idle_req && !master_port.wen && !w_hit && slave_port.gnt;
            assign w_wr_hs      = w_idle_req && master_port.wen && slave_port.gnt;
            assign w_wr_upd     = w_wr_hs && w_hit;
            // A fill that overlaps a flush in this RD_WAIT is forwarded but never kept.
            assign w_store      = resetn_i && (r_state == RD_WAIT) && slave_port.r_valid
                                  && !flush_i && !r_flushed;

            // Tag lookup against all valid lines.
            always_comb begin
                w_hit     = 1'b0;
                w_hit_idx = '0;
                for (int unsigned i = 0; i < NB_LINES; i++) begin
                    if (r_vld[i] && (r_tag[i] == w_tag)) begin
                        w_hit     = 1'b1;
                        w_hit_idx = IDX_W'(i);
                    end
                end
            end

            // Victim: lowest invalid line, otherwise the round-robin pointer.
            always_comb begin
                w_free = 1'b0;
                w_vict = r_rr;
                for (int unsigned i = 0; i < NB_LINES; i++) begin
                    if (!w_free && !r_vld[i]) begin
                        w_free = 1'b1;
                        w_vict = IDX_W'(i);
                    end
                end
            end

            always_comb begin
                w_s_req    = 1'b0;
                w_s_rready = 1'b0;
                w_m_gnt    = 1'b0;
                w_m_rvalid = 1'b0;
                w_m_rdata  = r_rdata;
                if (resetn_i) begin
                    case (r_state)
                        IDLE: begin
                            if (master_port.req) begin
                                if (master_port.wen || !w_hit) begin
                                    w_s_req = 1'b1;
                                    w_m_gnt = slave_port.gnt;
                                end else begin
                                    w_m_gnt = 1'b1;
                                end
                            end
                        end
                        RD_WAIT: begin
                            w_s_rready = 1'b1;
                            if (slave_port.r_valid) begin
                                w_m_rvalid = 1'b1;
                                w_m_rdata  = w_fill_word;
                            end
                        end
                        RESP: w_m_rvalid = 1'b1;
                        default: ;
                    endcase
                end
            end

            assign slave_port.req      = w_s_req;
            assign slave_port.wen      = master_port.wen;
            assign slave_port.addr     = {master_port.addr[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
            assign slave_port.be       = w_be;
            assign slave_port.data     = w_wdata;
            assign slave_port.r_ready  = w_s_rready;
            assign master_port.gnt     = w_m_gnt;
            assign master_port.r_valid = w_m_rvalid;
            assign master_port.r_data  = w_m_rdata;
            assign hit_cnt_o           = r_hit_cnt;
            assign miss_cnt_o          = r_miss_cnt;

            always_ff @(posedge clk_i) begin
                if (!resetn_i) begin
                    r_state    <= IDLE;
                    r_vld      <= '0;
                    r_rr       <= '0;
                    r_off      <= '0;
                    r_pend_tag <= '0;
                    r_flushed  <= 1'b0;
                    r_rdata    <= '0;
                    r_hit_cnt  <= '0;
                    r_miss_cnt <= '0;
                end else begin
                    case (r_state)
                        IDLE: begin
                            if (w_rd_hit) begin
                                r_rdata <= w_hit_word;
                                r_state <= RESP;
                                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
                            end else if (w_rd_miss_hs) begin
                                r_off      <= w_off;
                                r_pend_tag <= w_tag;
                                r_flushed  <= 1'b0;
                                r_state    <= RD_WAIT;
                                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
                            end
`ifndef WCC_WRITE_UPDATE_EN
                            if (w_wr_upd) r_vld[w_hit_idx] <= 1'b0;
`endif
                        end
                        RD_WAIT: begin
                            if (flush_i) r_flushed <= 1'b1;
                            if (slave_port.r_valid) begin
                                r_rdata <= w_fill_word;
                                r_state <= master_port.r_ready ? IDLE : RESP;
                            end
                            if (w_store) begin
                                r_vld[w_vict] <= 1'b1;
                                r_rr <= (r_rr == IDX_W'(NB_LINES - 1)) ? '0 : r_rr + IDX_W'(1);
                            end
                        end
                        RESP: begin
                            if (master_port.r_ready) r_state <= IDLE;
                        end
                        default: r_state <= IDLE;
                    endcase
                    if (flush_i) r_vld <= '0;
                end
            end

            // Line storage carries no reset; validity is tracked by r_vld.
            always_ff @(posedge clk_i) begin
                if (w_store) begin
                    r_line[w_vict] <= slave_port.r_data;
                    r_tag[w_vict]  <= r_pend_tag;
                end
`ifdef WCC_WRITE_UPDATE_EN
                if (w_wr_upd) begin
                    for (int unsigned b = 0; b < SLV_BYTES; b++) begin
                        if (w_be[b]) r_line[w_hit_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                    end
                end
`endif
            end
        end
    endgenerate
endmodule
